// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads and buffers returned words
// for in-order {inst, pc} delivery to the decoder. A redirect flushes and reloads the PC.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemGnt,
  input  logic        iMemRvalid,
  input  logic [31:0] iMemRdata,
  output logic [31:0] oInst,
  output logic [31:0] oCurPc,
  output logic        oValid,
  input  logic        iReady
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][31:0] entPc;
  logic [FIFO_DEPTH-1:0][31:0] entInst;
  logic [FIFO_DEPTH-1:0]       entFilled;

  ptr_t        allocPtr, fillPtr, rdPtr, dropCnt;
  ptr_t        allocCnt, pendCnt, dropNext;
  logic [31:0] pc;
  logic        grant, pop, fillHit, dropHit;
  logic        unusedPcLsb;

  assign unusedPcLsb = ^iRedirectPc[1:0];

  assign allocCnt = allocPtr - rdPtr;
  assign pendCnt  = allocPtr - fillPtr;

  // Responses still owed to a flushed stream hold slots until they drain.
  assign oMemReq  = iRst && !iRedirect && ((allocCnt + dropCnt) < DEPTH);
  assign oMemAddr = pc;

  assign oValid = iRst && !iRedirect && entFilled[rdPtr[AW-1:0]];
  assign oInst  = entInst[rdPtr[AW-1:0]];
  assign oCurPc = entPc[rdPtr[AW-1:0]];

  assign grant   = oMemReq && iMemGnt;
  assign pop     = oValid && iReady;
  assign dropHit = iMemRvalid && (dropCnt != '0);
  assign fillHit = iMemRvalid && !iRedirect && (dropCnt == '0) && (pendCnt != '0);

  // On redirect every unfilled entry plus any already-pending drops becomes owed;
  // a response arriving in that same cycle pays one of them off.
  always_comb begin
    dropNext = dropCnt + pendCnt;
    if (iMemRvalid && (dropNext != '0)) dropNext = dropNext - ptr_t'(1);
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      pc       <= RESET_PC;
      allocPtr <= '0;
      fillPtr  <= '0;
      rdPtr    <= '0;
      dropCnt  <= '0;
    end else if (iRedirect) begin
      pc       <= {iRedirectPc[31:2], 2'b00};
      allocPtr <= '0;
      fillPtr  <= '0;
      rdPtr    <= '0;
      dropCnt  <= dropNext;
    end else begin
      if (grant) begin
        pc       <= pc + 32'd4;
        allocPtr <= allocPtr + ptr_t'(1);
      end
      if (dropHit) dropCnt <= dropCnt - ptr_t'(1);
      if (fillHit) fillPtr <= fillPtr + ptr_t'(1);
      if (pop)     rdPtr   <= rdPtr + ptr_t'(1);
    end
  end

  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : gEnt
    inst_fetch_entry uEnt (
      .iClk      (iClk),
      .iRst      (iRst),
      .iFlush    (iRedirect),
      .iAlloc    (grant   && (allocPtr[AW-1:0] == AW'(g))),
      .iAllocPc  (pc),
      .iFill     (fillHit && (fillPtr[AW-1:0]  == AW'(g))),
      .iFillData (iMemRdata),
      .iFree     (pop     && (rdPtr[AW-1:0]    == AW'(g))),
      .oPc       (entPc[g]),
      .oInst     (entInst[g]),
      .oFilled   (entFilled[g])
    );
  end
endmodule

// One buffer slot; alloc, fill and free always target distinct slots in a cycle.
module inst_fetch_entry (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iFlush,
  input  logic        iAlloc,
  input  logic [31:0] iAllocPc,
  input  logic        iFill,
  input  logic [31:0] iFillData,
  input  logic        iFree,
  output logic [31:0] oPc,
  output logic [31:0] oInst,
  output logic        oFilled
);
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oPc     <= '0;
      oInst   <= '0;
      oFilled <= 1'b0;
    end else begin
      if (iAlloc) oPc   <= iAllocPc;
      if (iFill)  oInst <= iFillData;
      if (iFlush || iFree || iAlloc) oFilled <= 1'b0;
      else if (iFill)                oFilled <= 1'b1;
    end
  end
endmodule
